// File: rtl/ahb_picomem_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ahb_picomem_slave_bridge
// Brief    : AHB-Lite single-transfer slave replayed onto a PicoRV32 native
//            memory port. Optional macro: AHB_PICOMEM_ALIGN_CHECK_EN.
// Revision : 1.0
// ============================================================================
module ahb_picomem_slave_bridge #(
    parameter int BIG_ENDIAN_AHB = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [3:0]  i_hprot,
    input  logic        i_hready,
    input  logic [31:0] i_hwdata,
    output logic        o_hreadyout,
    output logic        o_hresp,
    output logic [31:0] o_hrdata,
    output logic        o_mem_valid,
    output logic        o_mem_instr,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_RESP   = 3'd2,
        S_ERR1   = 3'd3,
        S_ERR2   = 3'd4
    } state_t;

    localparam logic        c_TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic        r_instr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [31:0] r_hrdata;
    logic        r_first;
    logic [15:0] r_cnt;

    logic        w_can_capture;
    logic        w_capture;
    logic        w_misaligned;
    logic        w_timeout;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata_in;
    logic        w_unused;

    function automatic logic [31:0] f_lane(input logic [31:0] d);
        if (BIG_ENDIAN_AHB != 0)
            return {d[7:0], d[15:8], d[23:16], d[31:24]};
        else
            return d;
    endfunction

    assign w_unused = ^{i_hprot[3:1], i_htrans[0]};

    assign w_can_capture = (r_state == S_IDLE) || (r_state == S_RESP) || (r_state == S_ERR2);
    assign w_capture     = w_can_capture && i_hsel && i_hready && i_htrans[1];
    assign w_timeout     = c_TO_EN && (r_cnt == c_TO_LAST);
    assign w_wdata_in    = f_lane(i_hwdata);

`ifdef AHB_PICOMEM_ALIGN_CHECK_EN
    assign w_misaligned = ((i_hsize == 3'd1) && i_haddr[0])
                       || ((i_hsize == 3'd2) && (i_haddr[1:0] != 2'b00))
                       || (i_hsize >= 3'd3);
`else
    assign w_misaligned = 1'b0;
`endif

    // Reads always fetch the full word; the master selects its own lane.
    always_comb begin
        w_strb = 4'b0000;
        if (i_hwrite) begin
            case (i_hsize)
                3'd0:    w_strb = 4'b0001 << i_haddr[1:0];
                3'd1:    w_strb = 4'b0011 << {i_haddr[1], 1'b0};
                default: w_strb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_RESP, S_ERR2: begin
                if (w_capture)
                    w_state_nxt = w_misaligned ? S_ERR1 : S_ACCESS;
                else
                    w_state_nxt = S_IDLE;
            end
            S_ACCESS: begin
                if (i_mem_ready)
                    w_state_nxt = S_RESP;
                else if (w_timeout)
                    w_state_nxt = S_ERR1;
            end
            S_ERR1:  w_state_nxt = S_ERR2;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr   <= 32'd0;
            r_instr  <= 1'b0;
            r_wstrb  <= 4'b0000;
            r_wdata  <= 32'd0;
            r_hrdata <= 32'd0;
            r_first  <= 1'b0;
            r_cnt    <= 16'd0;
        end else begin
            if (w_capture && !w_misaligned) begin
                r_addr  <= {i_haddr[31:2], 2'b00};
                r_instr <= ~i_hprot[0];
                r_wstrb <= w_strb;
                r_first <= 1'b1;
                r_cnt   <= 16'd0;
            end else if (r_state == S_ACCESS) begin
                r_first <= 1'b0;
                if (r_first)
                    r_wdata <= w_wdata_in;
                if (i_mem_ready)
                    r_hrdata <= f_lane(i_mem_rdata);
                else
                    r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // hwdata only becomes valid in the first ACCESS cycle, so pass it through
    // then and hold the registered copy afterwards.
    assign o_mem_wdata = ((r_state == S_ACCESS) && r_first) ? w_wdata_in : r_wdata;
    assign o_mem_valid = (r_state == S_ACCESS);
    assign o_mem_instr = r_instr;
    assign o_mem_addr  = r_addr;
    assign o_mem_wstrb = r_wstrb;
    assign o_hreadyout = !((r_state == S_ACCESS) || (r_state == S_ERR1));
    assign o_hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign o_hrdata    = r_hrdata;

endmodule
`default_nettype wire
